pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (F, D, E, M, W).
- Drives the stall and flush inputs of the stage registers (the stall/flush pipeline flops) between Fetch/Decode, Decode/Execute and Execute/Memory.
- Resolves four hazard sources: load-use interlock, multi-cycle execute ops (mul/div), branch mispredict in E, and trap redirect in M.
- Multi-cycle ops are sequenced by an internal FSM and down-counter.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 9 +
 rtl/pipeline_hazard_ctrl_mc_sequencer.sv | 59 +++++
 rtl/pipeline_hazard_ctrl.sv | 95 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller and its multi-cycle sequencer.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MC_BUSY = 1'b1
  } hazard_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_mc_sequencer.sv
// Multi-cycle execute sequencer: holds an op in E for MC_LATENCY cycles (or until McDoneE)
// and reports whether the front of the pipe must be held this cycle.
module mc_sequencer
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MC_LATENCY = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic McStartE,
  input  logic McDoneE,
  input  logic TrapM,
  output logic McStall,
  output logic McBusy
);

  localparam int MC_CNT_WIDTH = $clog2(MC_LATENCY);
  localparam logic [MC_CNT_WIDTH-1:0] CNT_LOAD = MC_CNT_WIDTH'(MC_LATENCY - 2);

  hazard_state_e state;
  logic [MC_CNT_WIDTH-1:0] mc_cnt;
  logic release_now;

  // The start cycle counts as the first of MC_LATENCY, so the counter loads MC_LATENCY-2.
  assign release_now = (state == MC_BUSY) && ((mc_cnt == '0) || McDoneE);

  always_ff @(posedge clk) begin
    if (reset || TrapM) begin
      state  <= IDLE;
      mc_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (McStartE) begin
            state  <= MC_BUSY;
            mc_cnt <= CNT_LOAD;
          end
        end
        MC_BUSY: begin
          if (release_now) begin
            state  <= IDLE;
            mc_cnt <= '0;
          end else begin
            mc_cnt <= mc_cnt - MC_CNT_WIDTH'(1);
          end
        end
        default: begin
          state  <= IDLE;
          mc_cnt <= '0;
        end
      endcase
    end
  end

  assign McStall = !reset && !TrapM &&
                   (((state == IDLE) && McStartE) || ((state == MC_BUSY) && !release_now));
  assign McBusy  = !reset && (state == MC_BUSY);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the F/D/E/M/W pipeline.
// Optional stall-cycle counter output StallCycles under macro HAZARD_PERF_COUNTER_EN.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MC_LATENCY     = 32,
  parameter int REG_ADDR_WIDTH = 5
`ifdef HAZARD_PERF_COUNTER_EN
  , parameter int PERF_WIDTH   = 32
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic                      UsesRs1D,
  input  logic                      UsesRs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic                      IsLoadE,
  input  logic                      McStartE,
  input  logic                      McDoneE,
  input  logic                      MispredictE,
  input  logic                      TrapM,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushM,
`ifdef HAZARD_PERF_COUNTER_EN
  output logic [PERF_WIDTH-1:0]     StallCycles,
`endif
  output logic                      McBusy
);

  logic mc_stall;
  logic load_use;

  mc_sequencer #(
    .MC_LATENCY(MC_LATENCY)
  ) u_seq (
    .clk     (clk),
    .reset   (reset),
    .McStartE(McStartE),
    .McDoneE (McDoneE),
    .TrapM   (TrapM),
    .McStall (mc_stall),
    .McBusy  (McBusy)
  );

  assign load_use = IsLoadE && (RdE != '0) &&
                    ((UsesRs1D && (Rs1D == RdE)) || (UsesRs2D && (Rs2D == RdE)));

  // Priority: trap > multi-cycle (start/busy, including its release cycle) > mispredict > load-use.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (reset) begin
      StallF = 1'b0;
    end else if (TrapM) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
    end else if (mc_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (McBusy) begin
      StallF = 1'b0;
    end else if (MispredictE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (load_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

`ifdef HAZARD_PERF_COUNTER_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCycles <= '0;
    end else if (StallF) begin
      StallCycles <= StallCycles + PERF_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; instances with MC_LATENCY=4 and MC_LATENCY=32 share stimulus.
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, RdE;
  logic       UsesRs1D, UsesRs2D, IsLoadE, McStartE, McDoneE, MispredictE, TrapM;

  logic sf4, sd4, se4, fd4, fe4, fm4, mb4;
  logic sf32, sd32, se32, fd32, fe32, fm32, mb32;
`ifdef HAZARD_PERF_COUNTER_EN
  logic [31:0] sc4, sc32;
`endif

  // Packed as {StallF,StallD,StallE,FlushD,FlushE,FlushM,McBusy}
  logic [6:0] o4, o32;
  assign o4  = {sf4, sd4, se4, fd4, fe4, fm4, mb4};
  assign o32 = {sf32, sd32, se32, fd32, fe32, fm32, mb32};

  int vectors = 0;
  int miscompares = 0;

  pipeline_hazard_ctrl #(.MC_LATENCY(4), .REG_ADDR_WIDTH(5)) dut4 (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .UsesRs1D(UsesRs1D),
    .UsesRs2D(UsesRs2D), .RdE(RdE), .IsLoadE(IsLoadE), .McStartE(McStartE),
    .McDoneE(McDoneE), .MispredictE(MispredictE), .TrapM(TrapM),
    .StallF(sf4), .StallD(sd4), .StallE(se4), .FlushD(fd4), .FlushE(fe4), .FlushM(fm4),
`ifdef HAZARD_PERF_COUNTER_EN
    .StallCycles(sc4),
`endif
    .McBusy(mb4)
  );

  pipeline_hazard_ctrl #(.MC_LATENCY(32), .REG_ADDR_WIDTH(5)) dut32 (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .UsesRs1D(UsesRs1D),
    .UsesRs2D(UsesRs2D), .RdE(RdE), .IsLoadE(IsLoadE), .McStartE(McStartE),
    .McDoneE(McDoneE), .MispredictE(MispredictE), .TrapM(TrapM),
    .StallF(sf32), .StallD(sd32), .StallE(se32), .FlushD(fd32), .FlushE(fe32), .FlushM(fm32),
`ifdef HAZARD_PERF_COUNTER_EN
    .StallCycles(sc32),
`endif
    .McBusy(mb32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] NONE     = 7'b0000000;
  localparam logic [6:0] LU       = 7'b1100100;
  localparam logic [6:0] MC_START = 7'b1110010;
  localparam logic [6:0] MC_HOLD  = 7'b1110011;
  localparam logic [6:0] MC_REL   = 7'b0000001;
  localparam logic [6:0] MISPRED  = 7'b0001100;
  localparam logic [6:0] TRAP_MC  = 7'b0001111;
  localparam logic [6:0] TRAP_IDL = 7'b0001110;

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; RdE = '0;
    UsesRs1D = 0; UsesRs2D = 0; IsLoadE = 0;
    McStartE = 0; McDoneE = 0; MispredictE = 0; TrapM = 0;
  endtask

  // Advance past the next active edge; inputs are then driven, outputs sampled at the negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic set_lu_rs1(input logic [4:0] r);
    IsLoadE = 1; RdE = r; Rs1D = r; UsesRs1D = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    McStartE = 1; TrapM = 1; MispredictE = 1;
    set_lu_rs1(5'd5);
    tick();
    @(negedge clk);
    vectors++;
    if (o4 !== NONE) begin
      miscompares++; $display("FAIL reset_outs4 got %b want %b", o4, NONE);
    end
    vectors++;
    if (o32 !== NONE) begin
      miscompares++; $display("FAIL reset_outs32 got %b want %b", o32, NONE);
    end
    tick();
    reset = 0;
    clear_inputs();
    @(negedge clk);
    vectors++;
    if (o32 !== NONE) begin
      miscompares++; $display("FAIL post_reset_idle got %b want %b", o32, NONE);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [6:0] exp;
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      case (i)
        0: begin set_lu_rs1(5'd5); exp = LU; end
        1: begin Rs1D = 5'd5; UsesRs1D = 1; RdE = 5'd5; exp = NONE; end
        2: begin set_lu_rs1(5'd0); exp = NONE; end
        3: begin IsLoadE = 1; RdE = 5'd9; Rs2D = 5'd9; UsesRs2D = 1; Rs1D = 5'd3; UsesRs1D = 1; exp = LU; end
        default: begin IsLoadE = 1; RdE = 5'd9; Rs2D = 5'd9; UsesRs2D = 0; exp = NONE; end
      endcase
      @(negedge clk);
      vectors++;
      if (o4 !== exp) begin
        miscompares++; $display("FAIL load_use[%0d] got %b want %b", i, o4, exp);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_multicycle();
    logic [6:0] exp [5];
    exp[0] = MC_START; exp[1] = MC_HOLD; exp[2] = MC_HOLD; exp[3] = MC_REL; exp[4] = MC_START;
    do_reset();
    McStartE = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (o4 !== exp[i]) begin
        miscompares++; $display("FAIL mc_lat4 cycle %0d got %b want %b", i + 1, o4, exp[i]);
      end
      tick();
    end
    do_reset();
  endtask

  task automatic test_mc_done();
    logic [6:0] exp [5];
    exp[0] = MC_START; exp[1] = MC_HOLD; exp[2] = MC_HOLD; exp[3] = MC_REL; exp[4] = NONE;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      McStartE = (i < 4);
      McDoneE  = (i == 3);
      @(negedge clk);
      vectors++;
      if (o32 !== exp[i]) begin
        miscompares++; $display("FAIL mc_done cycle %0d got %b want %b", i + 1, o32, exp[i]);
      end
      tick();
    end
    do_reset();
  endtask

  task automatic test_mispredict();
    do_reset();
    MispredictE = 1;
    set_lu_rs1(5'd7);
    @(negedge clk);
    vectors++;
    if (o4 !== MISPRED) begin
      miscompares++; $display("FAIL mispredict_over_lu got %b want %b", o4, MISPRED);
    end
    tick();
    clear_inputs();
    McStartE = 1;
    tick();
    MispredictE = 1;
    @(negedge clk);
    vectors++;
    if (o4 !== MC_HOLD) begin
      miscompares++; $display("FAIL mispredict_in_busy got %b want %b", o4, MC_HOLD);
    end
    tick();
    do_reset();
  endtask

  task automatic test_mc_with_lu();
    do_reset();
    McStartE = 1;
    set_lu_rs1(5'd12);
    @(negedge clk);
    vectors++;
    if (o4 !== MC_START) begin
      miscompares++; $display("FAIL mc_start_with_lu got %b want %b", o4, MC_START);
    end
    tick();
    do_reset();
  endtask

  task automatic test_trap();
    do_reset();
    TrapM = 1;
    @(negedge clk);
    vectors++;
    if (o32 !== TRAP_IDL) begin
      miscompares++; $display("FAIL trap_idle got %b want %b", o32, TRAP_IDL);
    end
    tick();
    TrapM = 0;
    McStartE = 1;
    for (int i = 0; i < 5; i++) tick();
    TrapM = 1;
    @(negedge clk);
    vectors++;
    if (o32 !== TRAP_MC) begin
      miscompares++; $display("FAIL trap_in_busy got %b want %b", o32, TRAP_MC);
    end
    tick();
    TrapM = 0;
    McStartE = 0;
    @(negedge clk);
    vectors++;
    if (o32 !== NONE) begin
      miscompares++; $display("FAIL after_trap got %b want %b", o32, NONE);
    end
    tick();
    McStartE = 1;
    tick();
    tick();
    reset = 1;
    @(negedge clk);
    vectors++;
    if (o32 !== NONE) begin
      miscompares++; $display("FAIL reset_in_busy got %b want %b", o32, NONE);
    end
    tick();
    reset = 0;
    McStartE = 0;
    @(negedge clk);
    vectors++;
    if (o32 !== NONE) begin
      miscompares++; $display("FAIL after_reset_busy got %b want %b", o32, NONE);
    end
    vectors++;
    if (dut32.u_seq.mc_cnt !== 5'd0) begin
      miscompares++; $display("FAIL mc_cnt_after_reset got %0d want 0", dut32.u_seq.mc_cnt);
    end
    tick();
  endtask

`ifdef HAZARD_PERF_COUNTER_EN
  task automatic test_perf_counter();
    do_reset();
    @(negedge clk);
    vectors++;
    if (sc4 !== 32'd0) begin
      miscompares++; $display("FAIL stall_cycles_reset got %0d want 0", sc4);
    end
    tick();
    McStartE = 1;
    for (int i = 0; i < 4; i++) tick();
    McStartE = 0;
    set_lu_rs1(5'd5);
    tick();
    clear_inputs();
    @(negedge clk);
    vectors++;
    if (sc4 !== 32'd4) begin
      miscompares++; $display("FAIL stall_cycles got %0d want 4", sc4);
    end
    tick();
    do_reset();
  endtask
`endif

  initial begin
    reset = 1;
    clear_inputs();
    tick();
    test_reset();
    test_load_use();
    test_multicycle();
    test_mc_done();
    test_mispredict();
    test_mc_with_lu();
    test_trap();
`ifdef HAZARD_PERF_COUNTER_EN
    test_perf_counter();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
